// File: rtl/rs_pool_pkg.sv
// Shared reservation-station types and default sizing, also used by the
// decode stage and the FU wrappers.
package rs_pkg;

    localparam int RS_NUM_ENTRIES = 8;
    localparam int RS_NUM_FU      = 4;
    localparam int RS_NUM_CDB     = 2;
    localparam int RS_TAG_W       = 5;
    localparam int RS_DATA_W      = 32;
    localparam int RS_OP_W        = 32;

    typedef enum logic [1:0] {
        RS_FU_ALU   = 2'd0,
        RS_FU_LOAD  = 2'd1,
        RS_FU_STORE = 2'd2,
        RS_FU_FP    = 2'd3
    } RS_FU_T;

    typedef struct packed {
        logic                 busy;
        RS_FU_T               fu;
        logic [RS_OP_W-1:0]   op;
        logic [RS_TAG_W-1:0]  dest_tag;
        logic                 s1_rdy;
        logic [RS_TAG_W-1:0]  s1_tag;
        logic [RS_DATA_W-1:0] s1_val;
        logic                 s2_rdy;
        logic [RS_TAG_W-1:0]  s2_tag;
        logic [RS_DATA_W-1:0] s2_val;
    } RS_ENTRY_T;

endpackage

// File: rtl/rs_pool_psel.sv
// Lowest-index priority select: one-hot grant plus binary index of the
// lowest set request bit (both zero when nothing requests).
module rs_psel #(
    parameter int N  = 8,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    always_comb begin
        gnt = '0;
        idx = '0;
        // Scan downwards so the lowest requesting index is the last writer.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                gnt    = '0;
                gnt[i] = 1'b1;
                idx    = IW'(i);
            end
        end
    end

endmodule

// File: rtl/rs_pool.sv
// Reservation-station pool: dispatch with CDB bypass, per-entry operand
// wakeup, and one lowest-index issue per FU class with a stable hold.
module rs_pool
    import rs_pkg::*;
#(
    parameter int NUM_ENTRIES = RS_NUM_ENTRIES,
    parameter int NUM_FU      = RS_NUM_FU,
    parameter int NUM_CDB     = RS_NUM_CDB,
    parameter int TAG_W       = RS_TAG_W,
    parameter int DATA_W      = RS_DATA_W,
    parameter int OP_W        = RS_OP_W,
    localparam int FW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1,
    localparam int CW = $clog2(NUM_ENTRIES + 1)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      disp_valid,
    output logic                      disp_ready,
    input  logic [FW-1:0]             disp_fu,
    input  logic [OP_W-1:0]           disp_op,
    input  logic [TAG_W-1:0]          disp_dest_tag,
    input  logic                      disp_s1_rdy,
    input  logic [TAG_W-1:0]          disp_s1_tag,
    input  logic [DATA_W-1:0]         disp_s1_val,
    input  logic                      disp_s2_rdy,
    input  logic [TAG_W-1:0]          disp_s2_tag,
    input  logic [DATA_W-1:0]         disp_s2_val,
    input  logic [NUM_CDB-1:0]        cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0]  cdb_tag,
    input  logic [NUM_CDB*DATA_W-1:0] cdb_value,
    output logic [NUM_FU-1:0]         iss_valid,
    input  logic [NUM_FU-1:0]         iss_ready,
    output logic [NUM_FU*OP_W-1:0]    iss_op,
    output logic [NUM_FU*DATA_W-1:0]  iss_v1,
    output logic [NUM_FU*DATA_W-1:0]  iss_v2,
    output logic [NUM_FU*TAG_W-1:0]   iss_dest_tag,
    output logic [CW-1:0]             free_count
);

    localparam int IW = $clog2(NUM_ENTRIES);
    localparam logic [NUM_ENTRIES-1:0] ENTRY_ONE = {{(NUM_ENTRIES-1){1'b0}}, 1'b1};

    typedef struct packed {
        logic              busy;
        logic [FW-1:0]     fu;
        logic [OP_W-1:0]   op;
        logic [TAG_W-1:0]  dest_tag;
        logic              s1_rdy;
        logic [TAG_W-1:0]  s1_tag;
        logic [DATA_W-1:0] s1_val;
        logic              s2_rdy;
        logic [TAG_W-1:0]  s2_tag;
        logic [DATA_W-1:0] s2_val;
    } entry_t;

    entry_t                 entry_q [NUM_ENTRIES];
    entry_t                 entry_d [NUM_ENTRIES];
    logic [CW-1:0]          free_count_q, free_count_d;
    logic [NUM_FU-1:0]      lock_q, lock_d;
    logic [IW-1:0]          lock_idx_q [NUM_FU];
    logic [IW-1:0]          lock_idx_d [NUM_FU];

    logic [NUM_ENTRIES-1:0] free_vec, alloc_gnt, freed;
    logic [IW-1:0]          alloc_idx;
    logic                   disp_fire;
    logic [NUM_ENTRIES-1:0] elig     [NUM_FU];
    logic [NUM_ENTRIES-1:0] pick_gnt [NUM_FU];
    logic [NUM_ENTRIES-1:0] sel_gnt  [NUM_FU];
    logic [IW-1:0]          pick_idx [NUM_FU];
    logic [IW-1:0]          sel_idx  [NUM_FU];
    logic [NUM_FU-1:0]      iss_fire;
    logic [CW-1:0]          iss_cnt;

    assign free_count = free_count_q;
    assign disp_ready = (free_count_q != '0);
    assign disp_fire  = disp_valid & disp_ready & ~flush;

    rs_psel #(.N(NUM_ENTRIES)) u_alloc (
        .req (free_vec),
        .gnt (alloc_gnt),
        .idx (alloc_idx)
    );

    genvar gi, ge;
    generate
        for (ge = 0; ge < NUM_ENTRIES; ge++) begin : g_free
            assign free_vec[ge] = ~entry_q[ge].busy;
        end
        for (gi = 0; gi < NUM_FU; gi++) begin : g_fu
            for (ge = 0; ge < NUM_ENTRIES; ge++) begin : g_elig
                assign elig[gi][ge] = entry_q[ge].busy && (entry_q[ge].fu == FW'(gi))
                                   && entry_q[ge].s1_rdy && entry_q[ge].s2_rdy;
            end

            rs_psel #(.N(NUM_ENTRIES)) u_iss (
                .req (elig[gi]),
                .gnt (pick_gnt[gi]),
                .idx (pick_idx[gi])
            );

            // A stalled offer stays on the same entry even if a lower one becomes eligible.
            assign sel_gnt[gi] = lock_q[gi] ? (ENTRY_ONE << lock_idx_q[gi]) : pick_gnt[gi];
            assign sel_idx[gi] = lock_q[gi] ? lock_idx_q[gi] : pick_idx[gi];

            assign iss_valid[gi] = (|(sel_gnt[gi] & elig[gi])) & ~flush;
            assign iss_fire[gi]  = iss_valid[gi] & iss_ready[gi];

            assign iss_op[gi*OP_W +: OP_W] =
                iss_valid[gi] ? entry_q[sel_idx[gi]].op : '0;
            assign iss_v1[gi*DATA_W +: DATA_W] =
                iss_valid[gi] ? entry_q[sel_idx[gi]].s1_val : '0;
            assign iss_v2[gi*DATA_W +: DATA_W] =
                iss_valid[gi] ? entry_q[sel_idx[gi]].s2_val : '0;
            assign iss_dest_tag[gi*TAG_W +: TAG_W] =
                iss_valid[gi] ? entry_q[sel_idx[gi]].dest_tag : '0;
        end
    endgenerate

    always_comb begin
        freed   = '0;
        iss_cnt = '0;
        for (int f = 0; f < NUM_FU; f++) begin
            if (iss_fire[f]) begin
                freed   = freed | sel_gnt[f];
                iss_cnt = iss_cnt + CW'(1);
            end
        end
        lock_d       = iss_valid & ~iss_ready;
        lock_idx_d   = sel_idx;
        free_count_d = flush ? CW'(NUM_ENTRIES) : (free_count_q + iss_cnt - CW'(disp_fire));
    end

    always_comb begin
        entry_d = entry_q;
        for (int e = 0; e < NUM_ENTRIES; e++) begin
            if (freed[e]) entry_d[e].busy = 1'b0;
            if (entry_q[e].busy) begin
                // Descending channel order: the lowest matching channel wins.
                for (int c = NUM_CDB - 1; c >= 0; c--) begin
                    if (!entry_q[e].s1_rdy && cdb_valid[c]
                        && cdb_tag[c*TAG_W +: TAG_W] == entry_q[e].s1_tag) begin
                        entry_d[e].s1_rdy = 1'b1;
                        entry_d[e].s1_val = cdb_value[c*DATA_W +: DATA_W];
                    end
                    if (!entry_q[e].s2_rdy && cdb_valid[c]
                        && cdb_tag[c*TAG_W +: TAG_W] == entry_q[e].s2_tag) begin
                        entry_d[e].s2_rdy = 1'b1;
                        entry_d[e].s2_val = cdb_value[c*DATA_W +: DATA_W];
                    end
                end
            end
        end

        if (disp_fire) begin
            for (int e = 0; e < NUM_ENTRIES; e++) begin
                if (alloc_gnt[e]) entry_d[e].busy = 1'b1;
            end
            entry_d[alloc_idx].fu       = disp_fu;
            entry_d[alloc_idx].op       = disp_op;
            entry_d[alloc_idx].dest_tag = disp_dest_tag;
            entry_d[alloc_idx].s1_rdy   = disp_s1_rdy;
            entry_d[alloc_idx].s1_tag   = disp_s1_tag;
            entry_d[alloc_idx].s1_val   = disp_s1_val;
            entry_d[alloc_idx].s2_rdy   = disp_s2_rdy;
            entry_d[alloc_idx].s2_tag   = disp_s2_tag;
            entry_d[alloc_idx].s2_val   = disp_s2_val;
            for (int c = NUM_CDB - 1; c >= 0; c--) begin
                if (!disp_s1_rdy && cdb_valid[c] && cdb_tag[c*TAG_W +: TAG_W] == disp_s1_tag) begin
                    entry_d[alloc_idx].s1_rdy = 1'b1;
                    entry_d[alloc_idx].s1_val = cdb_value[c*DATA_W +: DATA_W];
                end
                if (!disp_s2_rdy && cdb_valid[c] && cdb_tag[c*TAG_W +: TAG_W] == disp_s2_tag) begin
                    entry_d[alloc_idx].s2_rdy = 1'b1;
                    entry_d[alloc_idx].s2_val = cdb_value[c*DATA_W +: DATA_W];
                end
            end
        end

        if (flush) begin
            for (int e = 0; e < NUM_ENTRIES; e++) begin
                entry_d[e].busy   = 1'b0;
                entry_d[e].s1_rdy = 1'b0;
                entry_d[e].s2_rdy = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        entry_q    <= entry_d;
        lock_idx_q <= lock_idx_d;
        if (!reset) begin
            for (int e = 0; e < NUM_ENTRIES; e++) begin
                entry_q[e].busy   <= 1'b0;
                entry_q[e].s1_rdy <= 1'b0;
                entry_q[e].s2_rdy <= 1'b0;
            end
            lock_q       <= '0;
            free_count_q <= CW'(NUM_ENTRIES);
        end else begin
            lock_q       <= lock_d;
            free_count_q <= free_count_d;
        end
    end

endmodule
